// File: rtl/seg_display_monitor.sv
// Receive-side monitor for the traffic-light 7-segment display bus: recovers the
// multiplexed main/side light codes and flags illegal glyphs, pairs, transitions and staleness.
module seg_display_monitor #(
  parameter int unsigned STABLE_CYC  = 4,
  parameter int unsigned TIMEOUT_CYC = 200000,
  parameter int unsigned TMR_W       = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] to_seg,
  input  logic [3:0] lights_on,
  output logic [1:0] main_light,
  output logic [1:0] side_light,
  output logic       valid,
  output logic       change,
  output logic       err_glyph,
  output logic       err_conflict,
  output logic       err_seq,
  output logic       stale
);

  localparam int unsigned CNT_W = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_M1  = CNT_W'(STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] TMO_FULL   = TMR_W'(TIMEOUT_CYC);
  localparam logic [TMR_W-1:0] TMO_M1     = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]       AN_MAIN    = 4'b0111;
  localparam logic [3:0]       AN_SIDE    = 4'b1110;

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_SETTLE,
    ST_ACCEPT,
    ST_WAIT
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [TMR_W-1:0] timer;

  logic [6:0]  seg_m, seg_s;
  logic [3:0]  an_m, an_s;
  logic [10:0] prev_bus;
  logic        bus_chg, an_valid, accept;

  logic [1:0]  main_pend, side_pend;
  logic        main_fresh, side_fresh, committed;
  logic        commit, differs, stale_hit;
  logic [2:0]  dec;
  logic [3:0]  pair_new, pair_old;

  function automatic logic [2:0] dec_main(input logic [6:0] g);
    case (g)
      7'b0000001: dec_main = 3'b100;
      7'b0010000: dec_main = 3'b101;
      7'b1011000: dec_main = 3'b110;
      7'b0111001: dec_main = 3'b111;
      default:    dec_main = 3'b000;
    endcase
  endfunction

  function automatic logic [2:0] dec_side(input logic [6:0] g);
    case (g)
      7'b0000001: dec_side = 3'b100;
      7'b0010000: dec_side = 3'b101;
      7'b1011000: dec_side = 3'b110;
      7'b0001000: dec_side = 3'b111;
      default:    dec_side = 3'b000;
    endcase
  endfunction

  function automatic logic legal_pair(input logic [3:0] p);
    case (p)
      4'b0000, 4'b0111, 4'b1011, 4'b1101, 4'b1110, 4'b1111: legal_pair = 1'b1;
      default: legal_pair = 1'b0;
    endcase
  endfunction

  function automatic logic legal_step(input logic [3:0] from, input logic [3:0] to);
    case ({from, to})
      {4'b0111, 4'b1011}, {4'b1011, 4'b1101}, {4'b1011, 4'b1111},
      {4'b1101, 4'b1110}, {4'b1110, 4'b0111}, {4'b1111, 4'b1101}: legal_step = 1'b1;
      default: legal_step = (from == 4'b0000);
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_m    <= '0;
      seg_s    <= '0;
      an_m     <= '0;
      an_s     <= '0;
      prev_bus <= '0;
    end else begin
      seg_m    <= to_seg;
      seg_s    <= seg_m;
      an_m     <= lights_on;
      an_s     <= an_m;
      prev_bus <= {an_s, seg_s};
    end
  end

  assign bus_chg  = ({an_s, seg_s} != prev_bus);
  assign an_valid = (an_s == AN_MAIN) || (an_s == AN_SIDE);
  assign accept   = (state == ST_ACCEPT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_HUNT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_HUNT: begin
        cnt_nxt = '0;
        if (an_valid) begin
          state_nxt = ST_SETTLE;
          cnt_nxt   = CNT_ONE;
        end
      end
      ST_SETTLE: begin
        if (!an_valid) begin
          state_nxt = ST_HUNT;
          cnt_nxt   = '0;
        end else if (bus_chg) begin
          cnt_nxt = CNT_ONE;
        end else if (cnt >= STABLE_M1) begin
          state_nxt = ST_ACCEPT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ST_ACCEPT: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (bus_chg) state_nxt = ST_HUNT;
      end
      default: state_nxt = ST_HUNT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                timer <= '0;
    else if (accept)           timer <= '0;
    else if (timer != TMO_FULL) timer <= timer + 1'b1;
  end

  // Decode from prev_bus: it holds the sample that completed settling, even if the bus moves during ACCEPT.
  assign dec       = (prev_bus[10:7] == AN_MAIN) ? dec_main(prev_bus[6:0]) : dec_side(prev_bus[6:0]);
  assign commit    = main_fresh && side_fresh;
  assign pair_new  = {main_pend, side_pend};
  assign pair_old  = {main_light, side_light};
  assign differs   = !committed || (pair_new != pair_old);
  assign stale_hit = !accept && (timer == TMO_M1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_pend    <= '0;
      side_pend    <= '0;
      main_fresh   <= 1'b0;
      side_fresh   <= 1'b0;
      committed    <= 1'b0;
      main_light   <= '0;
      side_light   <= '0;
      valid        <= 1'b0;
      change       <= 1'b0;
      err_glyph    <= 1'b0;
      err_conflict <= 1'b0;
      err_seq      <= 1'b0;
      stale        <= 1'b0;
    end else begin
      change <= 1'b0;
      if (commit) begin
        main_fresh <= 1'b0;
        side_fresh <= 1'b0;
        main_light <= main_pend;
        side_light <= side_pend;
        committed  <= 1'b1;
        valid      <= 1'b1;
        stale      <= 1'b0;
        change     <= differs;
        if (differs) begin
          if (!legal_pair(pair_new)) err_conflict <= 1'b1;
          if (committed && legal_pair(pair_old) && legal_pair(pair_new) &&
              !legal_step(pair_old, pair_new))
            err_seq <= 1'b1;
        end
      end else if (stale_hit) begin
        stale <= 1'b1;
        valid <= 1'b0;
      end

      if (accept) begin
        if (!dec[2]) begin
          err_glyph <= 1'b1;
        end else if (prev_bus[10:7] == AN_MAIN) begin
          main_pend  <= dec[1:0];
          main_fresh <= 1'b1;
        end else begin
          side_pend  <= dec[1:0];
          side_fresh <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_display_monitor.sv
// Scoreboard bench for seg_display_monitor: expected committed pairs are queued as the
// display bus is driven and popped on each change pulse.
module tb_seg_display_monitor;

  localparam int unsigned STABLE = 4;
  localparam int unsigned TMO    = 300;
  localparam int unsigned SLOT   = 50;

  localparam logic [6:0] G_OFF   = 7'b0000001;
  localparam logic [6:0] G_GRN   = 7'b0010000;
  localparam logic [6:0] G_YEL   = 7'b1011000;
  localparam logic [6:0] G_RED_M = 7'b0111001;
  localparam logic [6:0] G_RED_S = 7'b0001000;
  localparam logic [3:0] AN_MAIN  = 4'b0111;
  localparam logic [3:0] AN_SIDE  = 4'b1110;
  localparam logic [3:0] AN_BLANK = 4'b1111;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] to_seg = '0;
  logic [3:0] lights_on = AN_BLANK;
  logic [1:0] main_light, side_light;
  logic       valid, change, err_glyph, err_conflict, err_seq, stale;

  int asserts  = 0;
  int failures = 0;
  int pulses   = 0;

  logic [3:0] exp_q[$];
  logic [3:0] last_pair = '0;
  bit         seen_commit = 1'b0;
  logic [3:0] mon_exp;

  seg_display_monitor #(
    .STABLE_CYC (STABLE),
    .TIMEOUT_CYC(TMO),
    .TMR_W      (24)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .to_seg      (to_seg),
    .lights_on   (lights_on),
    .main_light  (main_light),
    .side_light  (side_light),
    .valid       (valid),
    .change      (change),
    .err_glyph   (err_glyph),
    .err_conflict(err_conflict),
    .err_seq     (err_seq),
    .stale       (stale)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && change) begin
      pulses++;
      asserts++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change got pair %0d/%0d required no pulse", main_light, side_light);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({main_light, side_light} !== mon_exp) begin
          failures++;
          $display("FAIL committed_pair got %0d/%0d required %0d/%0d",
                   main_light, side_light, mon_exp[3:2], mon_exp[1:0]);
        end
      end
    end
  end

  function automatic logic [6:0] main_seg(input logic [1:0] c);
    case (c)
      2'd0: main_seg = G_OFF;
      2'd1: main_seg = G_GRN;
      2'd2: main_seg = G_YEL;
      default: main_seg = G_RED_M;
    endcase
  endfunction

  function automatic logic [6:0] side_seg(input logic [1:0] c);
    case (c)
      2'd0: side_seg = G_OFF;
      2'd1: side_seg = G_GRN;
      2'd2: side_seg = G_YEL;
      default: side_seg = G_RED_S;
    endcase
  endfunction

  task automatic show(input logic [6:0] seg, input logic [3:0] an, input int n);
    @(negedge clk);
    to_seg    = seg;
    lights_on = an;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic drive_code(input logic [1:0] m, input logic [1:0] s);
    if (!seen_commit || {m, s} != last_pair) exp_q.push_back({m, s});
    last_pair   = {m, s};
    seen_commit = 1'b1;
    show(main_seg(m), AN_MAIN, SLOT);
    show(side_seg(s), AN_SIDE, SLOT);
    asserts++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_change got %0d queued required 0 for pair %0d/%0d", exp_q.size(), m, s);
    end
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    to_seg    = '0;
    lights_on = AN_BLANK;
    repeat (3) @(negedge clk);
    asserts++;
    if ({main_light, side_light, valid, change, err_glyph, err_conflict, err_seq, stale} !== 11'd0) begin
      failures++;
      $display("FAIL reset_outputs got %b required all zero",
               {main_light, side_light, valid, change, err_glyph, err_conflict, err_seq, stale});
    end
    reset = 1'b1;
    repeat (TMO - 10) @(negedge clk);
    asserts++;
    if (stale !== 1'b0) begin
      failures++;
      $display("FAIL stale_early got %b required 0", stale);
    end
    repeat (20) @(negedge clk);
    asserts++;
    if ({stale, valid} !== 2'b10) begin
      failures++;
      $display("FAIL stale_timeout got stale=%b valid=%b required stale=1 valid=0", stale, valid);
    end
  endtask

  task automatic test_first_commit;
    drive_code(2'd1, 2'd3);
    asserts++;
    if ({main_light, side_light, valid, stale} !== {2'd1, 2'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL first_commit got main=%0d side=%0d valid=%b stale=%b required 1/3 valid=1 stale=0",
               main_light, side_light, valid, stale);
    end
    asserts++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL first_pulses got %0d required 1", pulses);
    end
  endtask

  task automatic test_full_cycle;
    logic [3:0] seq [7] = '{4'b1011, 4'b1101, 4'b1110, 4'b0111, 4'b1011, 4'b1111, 4'b1101};
    int p0;
    p0 = pulses;
    foreach (seq[i]) drive_code(seq[i][3:2], seq[i][1:0]);
    drive_code(2'd3, 2'd2);
    asserts++;
    if (pulses - p0 !== 8) begin
      failures++;
      $display("FAIL cycle_pulses got %0d required 8", pulses - p0);
    end
    asserts++;
    if ({err_seq, err_conflict, err_glyph} !== 3'b000) begin
      failures++;
      $display("FAIL cycle_errors got seq/conf/glyph=%b required 000", {err_seq, err_conflict, err_glyph});
    end
  endtask

  task automatic test_glitch;
    int p0;
    p0 = pulses;
    show(G_RED_M, AN_MAIN, 20);
    show(G_GRN, AN_SIDE, STABLE - 1);
    show(G_RED_M, AN_MAIN, 30);
    show(G_YEL, AN_SIDE, SLOT);
    asserts++;
    if ({main_light, side_light, valid} !== {2'd3, 2'd2, 1'b1} || pulses !== p0) begin
      failures++;
      $display("FAIL glitch_hold got %0d/%0d valid=%b pulses+%0d required 3/2 valid=1 pulses+0",
               main_light, side_light, valid, pulses - p0);
    end
  endtask

  task automatic test_bad_glyph;
    show(G_RED_M, AN_MAIN, SLOT);
    show(G_RED_M, AN_SIDE, SLOT);
    asserts++;
    if (err_glyph !== 1'b1) begin
      failures++;
      $display("FAIL bad_glyph_flag got %b required 1", err_glyph);
    end
    asserts++;
    if ({main_light, side_light} !== {2'd3, 2'd2}) begin
      failures++;
      $display("FAIL bad_glyph_hold got %0d/%0d required 3/2", main_light, side_light);
    end
  endtask

  task automatic test_bad_seq;
    drive_code(2'd1, 2'd3);
    asserts++;
    if (err_seq !== 1'b0) begin
      failures++;
      $display("FAIL legal_step got err_seq=%b required 0", err_seq);
    end
    drive_code(2'd3, 2'd1);
    asserts++;
    if ({err_seq, err_conflict} !== 2'b10) begin
      failures++;
      $display("FAIL illegal_step got seq/conf=%b required 10", {err_seq, err_conflict});
    end
  endtask

  task automatic test_conflict;
    drive_code(2'd1, 2'd1);
    asserts++;
    if ({err_conflict, main_light, side_light} !== {1'b1, 2'd1, 2'd1}) begin
      failures++;
      $display("FAIL conflict got err_conflict=%b pair %0d/%0d required 1 and 1/1",
               err_conflict, main_light, side_light);
    end
  endtask

  task automatic test_reset_mid;
    show(G_YEL, AN_MAIN, 4);
    reset = 1'b0;
    #1;
    asserts++;
    if ({main_light, side_light, valid, change, err_glyph, err_conflict, err_seq, stale} !== 11'd0) begin
      failures++;
      $display("FAIL midreset_outputs got %b required all zero",
               {main_light, side_light, valid, change, err_glyph, err_conflict, err_seq, stale});
    end
    repeat (2) @(negedge clk);
    reset       = 1'b1;
    seen_commit = 1'b0;
    drive_code(2'd3, 2'd1);
    asserts++;
    if ({main_light, side_light, valid, err_seq} !== {2'd3, 2'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL post_reset_commit got %0d/%0d valid=%b err_seq=%b required 3/1 valid=1 err_seq=0",
               main_light, side_light, valid, err_seq);
    end
  endtask

  initial begin
    test_reset;
    test_first_commit;
    test_full_cycle;
    test_glitch;
    test_bad_glyph;
    test_bad_seq;
    test_conflict;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
